alu_exec_stage: RTL and testbench

//  Registered Y86 execute stage: selects ALU operands from icode, performs add/sub/and/xor,

---
 rtl/alu_exec_stage_pkg.sv | 65 ++++++
 rtl/alu_exec_stage_if.sv | 34 +++
 rtl/alu_mul_iter.sv | 52 +++++
 rtl/alu_exec_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared Y86 execute-stage definitions: icodes, ALU functions, CC bit indices,
// relation codes, FSM state type and the branch/cmov condition evaluator.
package alu_exec_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    // cc is packed as {OF,SF,ZF}
    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;
    localparam logic [2:0] CC_RESET = 3'b001;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (fn)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode->execute->memory bus for alu_exec_stage, with debug visibility of the FSM state.
interface alu_exec_stage_if
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_WID = 64
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // a producer holds valid and its payload stable until that edge, ready may toggle freely.
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valB;
    logic [DATA_WID-1:0] valC;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_WID-1:0] valE;
    logic                cnd;
    logic [2:0]          cc;
    logic                busy;
    state_t              state_dbg;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, out_ready,
        input  in_ready, out_valid, valE, cnd, cc, busy, state_dbg
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, out_ready,
        output in_ready, out_valid, valE, cnd, cc, busy, state_dbg
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle; built only
// when ALU_MUL_EN is defined. done pulses in the last step with product valid alongside.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W);

    logic           running;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;

    // product is the accumulator after the current step, so the final step's value is usable the same cycle
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_exec_stage.sv
// Registered Y86 execute stage: operand select, ALU, condition codes and cnd.
// Optional iterative MUL (OP ifun=4) is enabled by defining ALU_MUL_EN.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_WID   = 64,
    parameter int STACK_STEP = 8
) (
    input logic             clk,
    input logic             rst,
    alu_exec_stage_if.slave bus
);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int         M      = DATA_WID - 1;
    localparam logic [3:0] FN_MAX = MUL_EN ? ALU_MUL : ALU_XOR;

    state_t              state_q;
    state_t              state_d;
    logic                out_valid_q;
    logic [DATA_WID-1:0] valE_q;
    logic                cnd_q;
    logic [2:0]          cc_q;

    logic                in_ready;
    logic                accept;
    logic                is_op;
    logic                op_bad;
    logic                is_mul_op;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_WID-1:0] mul_prod;
    logic [DATA_WID-1:0] alu_a;
    logic [DATA_WID-1:0] alu_b;
    logic [DATA_WID-1:0] alu_r;
    logic [3:0]          alufun;
    logic                alu_of;
    logic [2:0]          cc_new;
    logic                cnd_new;
    logic [DATA_WID-1:0] mul_lo;
    logic [2:0]          mul_cc;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign is_op     = (bus.icode == I_OPQ);
    assign op_bad    = is_op && (bus.ifun > FN_MAX);
    assign is_mul_op = MUL_EN && is_op && (bus.ifun == ALU_MUL);
    assign mul_start = accept && is_mul_op;

    always_comb begin
        alu_a = '0;
        case (bus.icode)
            I_OPQ, I_RRMOVQ:                  alu_a = bus.valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     alu_a = bus.valC;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:   alu_a = DATA_WID'(STACK_STEP);
            I_HALT, I_NOP, I_JXX:             alu_a = '0;
            default:                          alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (bus.icode)
            I_OPQ, I_RMMOVQ, I_MRMOVQ, I_PUSHQ, I_POPQ, I_CALL, I_RET: alu_b = bus.valB;
            default:                                                  alu_b = '0;
        endcase
    end

    always_comb begin
        alufun = ALU_ADD;
        if (bus.icode == I_PUSHQ || bus.icode == I_CALL) begin
            alufun = ALU_SUB;
        end else if (is_op) begin
            alufun = bus.ifun;
        end
    end

    // SUB is B-A, matching the Y86 convention that subq rA,rB writes rB-rA
    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (alufun)
            ALU_ADD: begin
                alu_r  = alu_b + alu_a;
                alu_of = (alu_a[M] == alu_b[M]) && (alu_r[M] != alu_a[M]);
            end
            ALU_SUB: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_a[M] != alu_b[M]) && (alu_r[M] != alu_b[M]);
            end
            ALU_AND: alu_r = alu_a & alu_b;
            ALU_XOR: alu_r = alu_a ^ alu_b;
            default: alu_r = '0;
        endcase
        if (op_bad) begin
            alu_r  = '0;
            alu_of = 1'b0;
        end
    end

    always_comb begin
        cc_new        = '0;
        cc_new[CC_ZF] = (alu_r == '0);
        cc_new[CC_SF] = alu_r[M];
        cc_new[CC_OF] = alu_of;
    end

    // cnd reads the registered flags, so a JXX right after an OP sees that OP's result
    assign cnd_new = (bus.icode == I_JXX || bus.icode == I_CMOVXX) ? cond_eval(bus.ifun, cc_q) : 1'b1;

`ifdef ALU_MUL_EN
    alu_mul_iter #(
        .W(DATA_WID)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (alu_a),
        .b       (alu_b),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    assign mul_lo = mul_prod[DATA_WID-1:0];

    always_comb begin
        mul_cc        = '0;
        mul_cc[CC_ZF] = (mul_lo == '0);
        mul_cc[CC_SF] = mul_lo[M];
        mul_cc[CC_OF] = |mul_prod[2*DATA_WID-1:DATA_WID];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
            cc_q        <= CC_RESET;
        end else if (accept && !is_mul_op) begin
            out_valid_q <= 1'b1;
            valE_q      <= alu_r;
            cnd_q       <= cnd_new;
            if (is_op && !op_bad) begin
                cc_q <= cc_new;
            end
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            valE_q      <= mul_lo;
            cnd_q       <= 1'b1;
            cc_q        <= mul_cc;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.valE      = valE_q;
    assign bus.cnd       = cnd_q;
    assign bus.cc        = cc_q;
    assign bus.busy      = (state_q == ST_MUL);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus a randomized
// scoreboard run; MUL scenarios are included when ALU_MUL_EN is defined.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_cnd_q[$];
  logic [2:0]   exp_cc_q[$];
  logic [2:0]   cc_m = 3'b001;

  alu_exec_stage_if #(.DATA_WID(W)) bus ();

  alu_exec_stage #(.DATA_WID(W), .STACK_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.icode = 4'h1;
    bus.ifun = 4'h0;
    bus.valA = '0;
    bus.valB = '0;
    bus.valC = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cc_m = 3'b001;
    exp_q.delete();
    exp_cnd_q.delete();
    exp_cc_q.delete();
    #1;
  endtask

  // reference model: computes expected outputs at the moment of acceptance
  task automatic model_push(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] e;
    logic cd;
    logic [2:0] ccn;
    logic [W:0] ext;
    logic [2*W-1:0] p;
    logic z, s, o;
    z = cc_m[0];
    s = cc_m[1];
    o = cc_m[2];
    cd = 1'b1;
    if (ic == 4'h7 || ic == 4'h2) begin
      case (fn)
        4'd0: cd = 1'b1;
        4'd1: cd = (s ^ o) | z;
        4'd2: cd = s ^ o;
        4'd3: cd = z;
        4'd4: cd = ~z;
        4'd5: cd = ~(s ^ o);
        4'd6: cd = ~(s ^ o) & ~z;
        default: cd = 1'b0;
      endcase
    end
    e = '0;
    ccn = cc_m;
    p = '0;
    case (ic)
      4'h6: begin
        case (fn)
          4'd0: begin
            e = b + a;
            ext = {a[W-1], a} + {b[W-1], b};
            ccn = {ext[W] != ext[W-1], e[W-1], e == '0};
          end
          4'd1: begin
            e = b - a;
            ext = {b[W-1], b} - {a[W-1], a};
            ccn = {ext[W] != ext[W-1], e[W-1], e == '0};
          end
          4'd2: begin e = a & b; ccn = {1'b0, e[W-1], e == '0}; end
          4'd3: begin e = a ^ b; ccn = {1'b0, e[W-1], e == '0}; end
`ifdef ALU_MUL_EN
          4'd4: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e = p[W-1:0];
            ccn = {|p[2*W-1:W], e[W-1], e == '0};
          end
`endif
          default: e = '0;
        endcase
      end
      4'h2: e = a;
      4'h3: e = c;
      4'h4, 4'h5: e = b + c;
      4'h8, 4'hA: e = b - 64'd8;
      4'h9, 4'hB: e = b + 64'd8;
      default: e = '0;
    endcase
    cc_m = ccn;
    exp_q.push_back(e);
    exp_cnd_q.push_back(cd);
    exp_cc_q.push_back(ccn);
  endtask

  task automatic pop_expect(output logic [W-1:0] e, output logic cd, output logic [2:0] ccx);
    if (exp_q.size() == 0) begin
      e = 'x;
      cd = 1'bx;
      ccx = 3'bxxx;
    end else begin
      e = exp_q.pop_front();
      cd = exp_cnd_q.pop_front();
      ccx = exp_cc_q.pop_front();
    end
  endtask

  // driver: present one instruction at a negedge, hold until accepted, return at the next negedge
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int n;
    n = 0;
    bus.icode = ic;
    bus.ifun = fn;
    bus.valA = a;
    bus.valB = b;
    bus.valC = c;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL send_timeout icode=%0h in_ready=%0b required=1", ic, bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      model_push(ic, fn, a, b, c);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++;
    if (bus.valE !== '0) begin failures++; $display("FAIL reset_valE got=%0h exp=0", bus.valE); end
    checks++;
    if (bus.cnd !== 1'b0) begin failures++; $display("FAIL reset_cnd got=%0b exp=0", bus.cnd); end
    checks++;
    if (bus.cc !== 3'b001) begin failures++; $display("FAIL reset_cc got=%b exp=001", bus.cc); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++;
    if (bus.state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, ST_IDLE); end
  endtask

  task automatic test_cmov_after_reset();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    send(4'h2, 4'd3, 64'h1234_5678_9abc_def0, 64'h55, 64'h0);
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.cnd !== cd || bus.valE !== e) begin
      failures++;
      $display("FAIL cmov_after_reset got v=%0b cnd=%0b valE=%0h exp v=1 cnd=%0b valE=%0h", bus.out_valid, bus.cnd, bus.valE, cd, e);
    end
  endtask

  task automatic test_add_overflow();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    send(4'h6, 4'd0, 64'd1, 64'h7fff_ffff_ffff_ffff, 64'h0);
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_latency out_valid=%0b exp=1", bus.out_valid); end
    checks++;
    if (bus.valE !== e) begin failures++; $display("FAIL add_valE got=%0h exp=%0h", bus.valE, e); end
    checks++;
    if (bus.cc !== ccx) begin failures++; $display("FAIL add_cc got=%b exp=%b", bus.cc, ccx); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    bus.out_ready = 1'b1;
    send(4'h6, 4'd1, 64'd5, 64'd5, 64'h0);
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.valE !== e || bus.cc !== ccx) begin
      failures++;
      $display("FAIL sub_equal got valE=%0h cc=%b exp valE=%0h cc=%b", bus.valE, bus.cc, e, ccx);
    end
    send(4'h7, 4'd3, 64'h0, 64'h0, 64'h400);
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.cnd !== cd) begin failures++; $display("FAIL jxx_e_after_sub got=%0b exp=%0b", bus.cnd, cd); end
    send(4'h7, 4'd4, 64'h0, 64'h0, 64'h400);
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.cnd !== cd) begin failures++; $display("FAIL jxx_ne_after_sub got=%0b exp=%0b", bus.cnd, cd); end
  endtask

  task automatic test_stack();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    logic [3:0] ics[4];
    ics[0] = 4'hA; ics[1] = 4'hB; ics[2] = 4'h8; ics[3] = 4'h9;
    for (int i = 0; i < 4; i++) begin
      send(ics[i], 4'd0, 64'hdead, 64'h100, 64'h0);
      pop_expect(e, cd, ccx);
      checks++;
      if (bus.valE !== e || bus.cc !== ccx || bus.cnd !== cd) begin
        failures++;
        $display("FAIL stack_icode_%0h got valE=%0h cc=%b cnd=%0b exp valE=%0h cc=%b cnd=%0b",
                 ics[i], bus.valE, bus.cc, bus.cnd, e, ccx, cd);
      end
    end
  endtask

  task automatic test_invalid_op();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    logic [3:0] fns[2];
    send(4'h6, 4'd3, 64'hf0, 64'h0f, 64'h0);
    pop_expect(e, cd, ccx);
`ifdef ALU_MUL_EN
    fns[0] = 4'd5;
`else
    fns[0] = 4'd4;
`endif
    fns[1] = 4'd7;
    for (int i = 0; i < 2; i++) begin
      send(4'h6, fns[i], 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0);
      pop_expect(e, cd, ccx);
      checks++;
      if (bus.valE !== e || bus.cc !== ccx) begin
        failures++;
        $display("FAIL invalid_op_ifun_%0d got valE=%0h cc=%b exp valE=%0h cc=%b", fns[i], bus.valE, bus.cc, e, ccx);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    bus.out_ready = 1'b1;
    send(4'h6, 4'd3, 64'hff00, 64'h0ff0, 64'h0);
    pop_expect(e, cd, ccx);
    bus.out_ready = 1'b0;
    bus.icode = 4'h6;
    bus.ifun = 4'd0;
    bus.valA = 64'h7fff_ffff_ffff_ffff;
    bus.valB = 64'h7fff_ffff_ffff_ffff;
    bus.valC = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.valE !== e || bus.cc !== ccx) begin
        failures++;
        $display("FAIL stall_cycle_%0d got rdy=%0b v=%0b valE=%0h cc=%b exp rdy=0 v=1 valE=%0h cc=%b",
                 i, bus.in_ready, bus.out_valid, bus.valE, bus.cc, e, ccx);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_release in_ready=%0b exp=1", bus.in_ready); end
    model_push(bus.icode, bus.ifun, bus.valA, bus.valB, bus.valC);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.valE !== e || bus.cc !== ccx) begin
      failures++;
      $display("FAIL after_stall got v=%0b valE=%0h cc=%b exp v=1 valE=%0h cc=%b", bus.out_valid, bus.valE, bus.cc, e, ccx);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    int sent;
    int cyc;
    bit acc;
    sent = 0;
    cyc = 0;
    @(negedge clk);
    while ((sent < 60 || exp_q.size() > 0 || bus.out_valid) && cyc < 20000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && sent < 60 && $urandom_range(0, 1) == 1) begin
        bus.icode = 4'($urandom_range(0, 15));
        bus.ifun = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
        if ($urandom_range(0, 3) == 0) begin
          bus.valA = 64'($urandom_range(0, 3));
          bus.valB = 64'($urandom_range(0, 3));
        end else begin
          bus.valA = {$urandom(), $urandom()};
          bus.valB = {$urandom(), $urandom()};
        end
        bus.valC = {$urandom(), $urandom()};
        bus.in_valid = 1'b1;
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        pop_expect(e, cd, ccx);
        checks++;
        if (bus.valE !== e || bus.cnd !== cd || bus.cc !== ccx) begin
          failures++;
          $display("FAIL random_result cyc=%0d got valE=%0h cnd=%0b cc=%b exp valE=%0h cnd=%0b cc=%b",
                   cyc, bus.valE, bus.cnd, bus.cc, e, cd, ccx);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        model_push(bus.icode, bus.ifun, bus.valA, bus.valB, bus.valC);
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (cyc >= 20000) begin failures++; $display("FAIL random_timeout sent=%0d pending=%0d exp pending=0", sent, exp_q.size()); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [W-1:0] e; logic cd; logic [2:0] ccx;
    int n;
    bus.out_ready = 1'b1;
    send(4'h6, 4'd4, 64'd3, 64'd7, 64'h0);
    n = 0;
    while (bus.busy && n < 3 * W) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mul_busy_cycle_%0d got rdy=%0b v=%0b exp rdy=0 v=0", n, bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != W) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", n, W); end
    pop_expect(e, cd, ccx);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.valE !== e || bus.cc !== ccx) begin
      failures++;
      $display("FAIL mul_result got v=%0b valE=%0h cc=%b exp v=1 valE=%0h cc=%b", bus.out_valid, bus.valE, bus.cc, e, ccx);
    end
  endtask

  task automatic test_mul_reset();
    send(4'h6, 4'd0, 64'h7fff_ffff_ffff_ffff, 64'd1, 64'h0);
    send(4'h6, 4'd4, 64'd5, 64'd9, 64'h0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cc_m = 3'b001;
    exp_q.delete();
    exp_cnd_q.delete();
    exp_cc_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cc !== 3'b001 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mul_abort got v=%0b cc=%b busy=%0b exp v=0 cc=001 busy=0", bus.out_valid, bus.cc, bus.busy);
    end
    repeat (W + 4) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mul_abort_late out_valid=%0b exp=0", bus.out_valid); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.icode = 4'h1;
    bus.ifun = 4'h0;
    bus.valA = '0;
    bus.valB = '0;
    bus.valC = '0;
    test_reset();
    test_cmov_after_reset();
    test_add_overflow();
    test_back_to_back();
    test_stack();
    test_invalid_op();
    test_backpressure();
    test_random();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
